dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Request bundle, FSM states and fault rule.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // Misaligned, past the end of the array, or no lanes enabled.
  function automatic logic is_fault(req_t r, int unsigned depth);
    return (r.addr[1:0] != 2'b00)
        || ({2'b00, r.addr[31:2]} >= depth)
        || (r.be == '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-lane writes.
// One synchronous write port and one combinational read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [31:0]             wdata,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic [AW-1:0]           raddr,
  output logic [31:0]             rdata
);

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Valid/ready request and response with fixed wait latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state, state_n;
  logic [3:0]  cnt;
  req_t        req_q, act;
  logic        fault, enter, mem_we;
  logic [31:0] mem_rdata, lane_mask;

  // With zero latency the request is served on its own edge.
  always_comb begin
    act = req_q;
    if (state == S_IDLE) begin
      act.we    = req_we;
      act.addr  = req_addr;
      act.wdata = req_wdata;
      act.be    = req_be;
    end
  end

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      lane_mask[8*i +: 8] = {8{act.be[i]}};
    end
  end

  assign fault     = is_fault(act, DEPTH_WORDS);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (req_valid)
                state_n = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_n = S_RESP;
      S_RESP: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign enter  = (state != S_RESP) && (state_n == S_RESP);
  assign mem_we = enter && act.we && !fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req_valid) begin
        req_q <= act;
        cnt   <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter) begin
        rsp_err   <= fault;
        rsp_rdata <= (fault || act.we) ? '0
                                       : (mem_rdata & lane_mask);
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (act.addr[AW+1:2]),
    .wdata (act.wdata),
    .be    (act.be),
    .raddr (act.addr[AW+1:2]),
    .rdata (mem_rdata)
  );

endmodule
